// File: rtl/game_irq_scheduler.sv
// -----------------------------------------------------------------------------
// game_irq_scheduler
//
// Drives the kcpsm6 interrupt line for the game. Two event sources are merged:
//   * a periodic game tick whose period depends on the speed level, and
//   * the rising edge of the video controller's collision flag.
// Each source sets a sticky pending flag. The request/service handshake
// snapshots the pending flags into `cause` when the processor acknowledges.
// Ticks that arrive while a tick is already pending are counted in `overrun`.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active low
//   level          speed select, 1 = FAST_PERIOD, 0 = SLOW_PERIOD
//   pause          freezes the tick counter and suppresses tick events
//   collision      raw level-type collision flag
//   interrupt_ack  kcpsm6 acknowledge pulse
//   eoi            end-of-interrupt strobe from firmware
//   ovr_clr        clears the overrun counter
//   interrupt      registered interrupt request
//   cause          {collision, tick} captured at acknowledge
//   overrun        lost-tick counter, saturating at 255
//   busy           high while the handler is in service
// -----------------------------------------------------------------------------
module game_irq_scheduler #(
    parameter int SLOW_PERIOD = 10000000,
    parameter int FAST_PERIOD = 4000000,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level,
    input  logic       pause,
    input  logic       collision,
    input  logic       interrupt_ack,
    input  logic       eoi,
    input  logic       ovr_clr,
    output logic       interrupt,
    output logic [1:0] cause,
    output logic [7:0] overrun,
    output logic       busy
);

    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_PERIOD - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Tick counter and edge-detect history
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] period_last;
    logic             level_reg;
    logic             coll_reg;

    // Event and handshake decode
    logic level_change;
    logic tick_evt;
    logic coll_evt;
    logic ack_cap;

    // Pending flags and overrun
    logic       tick_pend_reg;
    logic       tick_pend_next;
    logic       coll_pend_reg;
    logic       coll_pend_next;
    logic       any_pend;
    logic [7:0] overrun_reg;
    logic [7:0] overrun_next;

    // FSM and registered outputs
    state_t     state_reg;
    logic       interrupt_reg;
    logic       busy_reg;
    logic [1:0] cause_reg;

    always_comb begin
        // level_reg is the period in force; when it differs from level the
        // counter is being restarted anyway, so no tick can be produced.
        period_last  = level_reg ? FAST_LAST : SLOW_LAST;
        level_change = (level != level_reg);
        tick_evt     = !pause && !level_change && (count_reg == period_last);
        coll_evt     = collision && !coll_reg;
        ack_cap      = (state_reg == REQ) && interrupt_ack;
        any_pend     = tick_pend_reg || coll_pend_reg;

        // A level change restarts the period even while paused.
        count_next = count_reg;
        if (level_change) begin
            count_next = '0;
        end else if (!pause) begin
            if (count_reg == period_last) begin
                count_next = '0;
            end else begin
                count_next = count_reg + CNT_W'(1);
            end
        end

        // Set wins over the clear from an acknowledge in the same cycle.
        tick_pend_next = tick_evt || (tick_pend_reg && !ack_cap);
        coll_pend_next = coll_evt || (coll_pend_reg && !ack_cap);

        // A clear coincident with a lost tick leaves that tick counted.
        overrun_next = overrun_reg;
        if (ovr_clr) begin
            overrun_next = (tick_evt && tick_pend_reg) ? 8'd1 : 8'd0;
        end else if (tick_evt && tick_pend_reg && (overrun_reg != 8'hFF)) begin
            overrun_next = overrun_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg     <= '0;
            level_reg     <= 1'b0;
            coll_reg      <= 1'b0;
            tick_pend_reg <= 1'b0;
            coll_pend_reg <= 1'b0;
            overrun_reg   <= 8'd0;
            state_reg     <= IDLE;
            interrupt_reg <= 1'b0;
            busy_reg      <= 1'b0;
            cause_reg     <= 2'b00;
        end else begin
            count_reg     <= count_next;
            level_reg     <= level;
            coll_reg      <= collision;
            tick_pend_reg <= tick_pend_next;
            coll_pend_reg <= coll_pend_next;
            overrun_reg   <= overrun_next;

            case (state_reg)
                IDLE: begin
                    if (any_pend) begin
                        state_reg     <= REQ;
                        interrupt_reg <= 1'b1;
                    end
                end
                REQ: begin
                    if (interrupt_ack) begin
                        cause_reg     <= {coll_pend_reg, tick_pend_reg};
                        interrupt_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        busy_reg <= 1'b0;
                        // Work that arrived during service is re-requested
                        // directly, without a detour through IDLE.
                        if (any_pend) begin
                            state_reg     <= REQ;
                            interrupt_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    interrupt_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt = interrupt_reg;
    assign cause     = cause_reg;
    assign overrun   = overrun_reg;
    assign busy      = busy_reg;

endmodule
